// File: rtl/usonic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usonic_pkg
// Description : Shared state encoding, parameter defaults and width helper
//               for the ultrasonic transmit scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package usonic_pkg;

    localparam int c_DEF_NUM_CH        = 4;
    localparam int c_DEF_HALF_PERIOD   = 512;
    localparam int c_DEF_BURST_PULSES  = 32;
    localparam int c_DEF_LISTEN_CYCLES = 560000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_BURST  = 2'd2,
        S_LISTEN = 2'd3
    } usonic_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usonic_carrier_gen.sv
`default_nettype none
// ============================================================================
// Module      : usonic_carrier_gen
// Description : Half-period / pulse counting for one carrier burst. carrier
//               is the level the selected p line must take on the next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module usonic_carrier_gen
    import usonic_pkg::*;
#(
    parameter int HALF_PERIOD  = c_DEF_HALF_PERIOD,
    parameter int BURST_PULSES = c_DEF_BURST_PULSES
) (
    input  logic CLK_40,
    input  logic RST_N,
    input  logic run,
    output logic carrier,
    output logic burst_last
);

    localparam int HW = cnt_w(HALF_PERIOD);
    localparam int PW = cnt_w(BURST_PULSES);
    localparam logic [HW-1:0] c_HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] c_PULSE_LAST = PW'(BURST_PULSES - 1);

    logic [HW-1:0] r_half_cnt;
    logic [PW-1:0] r_pulse_cnt;
    logic          r_low;
    logic          w_half_end;
    logic          w_pulse_end;

    assign w_half_end  = (r_half_cnt == c_HALF_LAST);
    assign w_pulse_end = (r_pulse_cnt == c_PULSE_LAST);

    // Counters describe the current burst cycle; all zero while not running
    // so the first burst cycle always starts a fresh high half.
    always_ff @(posedge CLK_40 or negedge RST_N) begin
        if (!RST_N) begin
            r_half_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_low       <= 1'b0;
        end else if (!run) begin
            r_half_cnt  <= '0;
            r_pulse_cnt <= '0;
            r_low       <= 1'b0;
        end else if (w_half_end) begin
            r_half_cnt <= '0;
            r_low      <= ~r_low;
            if (r_low && !w_pulse_end) begin
                r_pulse_cnt <= r_pulse_cnt + PW'(1);
            end
        end else begin
            r_half_cnt <= r_half_cnt + HW'(1);
        end
    end

    assign carrier    = !run ? 1'b1 : (w_half_end ? r_low : ~r_low);
    assign burst_last = run && r_low && w_half_end && w_pulse_end;

endmodule
`default_nettype wire

// File: rtl/usonic_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : usonic_tx_scheduler
// Description : Sweeps masked transducer channels: one carrier burst per
//               channel followed by an echo-listen window, single or continuous.
// Revision    : 1.0 - initial release
// ============================================================================
module usonic_tx_scheduler
    import usonic_pkg::*;
#(
    parameter int NUM_CH        = c_DEF_NUM_CH,
    parameter int HALF_PERIOD   = c_DEF_HALF_PERIOD,
    parameter int BURST_PULSES  = c_DEF_BURST_PULSES,
    parameter int LISTEN_CYCLES = c_DEF_LISTEN_CYCLES
) (
    input  logic                      CLK_40,
    input  logic                      RST_N,
    input  logic                      EN,
    input  logic                      MODE_CONT,
    input  logic                      START,
    input  logic [NUM_CH-1:0]         CH_MASK,
    output logic [2*NUM_CH-1:0]       pulseOutput,
    output logic [$clog2(NUM_CH)-1:0] CH_SEL,
    output logic                      TX_ACTIVE,
    output logic                      LISTEN,
    output logic                      FRAME_DONE,
    output logic                      BUSY
);

    localparam int SW = $clog2(NUM_CH);
    localparam int LW = cnt_w(LISTEN_CYCLES);
    localparam logic [LW-1:0] c_LISTEN_LAST = LW'(LISTEN_CYCLES - 1);

    usonic_state_t       r_state;
    usonic_state_t       w_state_nxt;
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   w_pending_nxt;
    logic [SW-1:0]       r_ch_sel;
    logic [SW-1:0]       w_ch_sel_nxt;
    logic [LW-1:0]       r_listen_cnt;
    logic [LW-1:0]       w_listen_cnt_nxt;
    logic [2*NUM_CH-1:0] r_pulse;
    logic [2*NUM_CH-1:0] w_pulse_nxt;
    logic                r_tx_active;
    logic                r_listen;
    logic                r_frame_done;
    logic                r_busy;
    logic                w_run;
    logic                w_carrier;
    logic                w_burst_last;
    logic                w_listen_last;

    assign w_run         = (r_state == S_BURST);
    assign w_listen_last = (r_listen_cnt == c_LISTEN_LAST);

    usonic_carrier_gen #(
        .HALF_PERIOD  (HALF_PERIOD),
        .BURST_PULSES (BURST_PULSES)
    ) u_carrier_gen (
        .CLK_40     (CLK_40),
        .RST_N      (RST_N),
        .run        (w_run),
        .carrier    (w_carrier),
        .burst_last (w_burst_last)
    );

    always_ff @(posedge CLK_40 or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_ch_sel_nxt  = r_ch_sel;
        if (!EN) begin
            w_state_nxt   = S_IDLE;
            w_pending_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((CH_MASK != '0) && (MODE_CONT || START)) begin
                        w_pending_nxt = CH_MASK;
                        w_state_nxt   = S_SELECT;
                    end
                end
                S_SELECT: begin
                    // Descending scan so the lowest pending index wins.
                    for (int i = NUM_CH - 1; i >= 0; i--) begin
                        if (r_pending[i]) begin
                            w_ch_sel_nxt = SW'(i);
                        end
                    end
                    w_pending_nxt = r_pending & (r_pending - NUM_CH'(1));
                    w_state_nxt   = S_BURST;
                end
                S_BURST: begin
                    if (w_burst_last) begin
                        w_state_nxt = S_LISTEN;
                    end
                end
                S_LISTEN: begin
                    if (w_listen_last) begin
                        if (r_pending != '0) begin
                            w_state_nxt = S_SELECT;
                        end else if (MODE_CONT && (CH_MASK != '0)) begin
                            w_pending_nxt = CH_MASK;
                            w_state_nxt   = S_SELECT;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_pending_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are precomputed from the next state so each one is a flop.
    always_comb begin
        w_listen_cnt_nxt = '0;
        if ((w_state_nxt == S_LISTEN) && (r_state == S_LISTEN)) begin
            w_listen_cnt_nxt = r_listen_cnt + LW'(1);
        end
        w_pulse_nxt = '0;
        if (w_state_nxt == S_BURST) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ch_sel_nxt == SW'(c)) begin
                    w_pulse_nxt[2*c +: 2] = {~w_carrier, w_carrier};
                end
            end
        end
    end

    always_ff @(posedge CLK_40 or negedge RST_N) begin
        if (!RST_N) begin
            r_pending    <= '0;
            r_ch_sel     <= '0;
            r_listen_cnt <= '0;
            r_pulse      <= '0;
            r_tx_active  <= 1'b0;
            r_listen     <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_ch_sel     <= w_ch_sel_nxt;
            r_listen_cnt <= w_listen_cnt_nxt;
            r_pulse      <= w_pulse_nxt;
            r_tx_active  <= (w_state_nxt == S_BURST);
            r_listen     <= (w_state_nxt == S_LISTEN);
            r_frame_done <= (w_state_nxt == S_LISTEN) && (w_listen_cnt_nxt == c_LISTEN_LAST);
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign pulseOutput = r_pulse;
    assign CH_SEL      = r_ch_sel;
    assign TX_ACTIVE   = r_tx_active;
    assign LISTEN      = r_listen;
    assign FRAME_DONE  = r_frame_done;
    assign BUSY        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_usonic_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_usonic_tx_scheduler
// Description : Directed self-checking bench for usonic_tx_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usonic_tx_scheduler;

    localparam int NUM_CH    = 4;
    localparam int HP        = 4;
    localparam int BP        = 3;
    localparam int LC        = 20;
    localparam int BURST_LEN = 2 * HP * BP;

    logic       CLK_40 = 1'b0;
    logic       RST_N;
    logic       EN;
    logic       MODE_CONT;
    logic       START;
    logic [3:0] CH_MASK;
    logic [7:0] pulseOutput;
    logic [1:0] CH_SEL;
    logic       TX_ACTIVE;
    logic       LISTEN;
    logic       FRAME_DONE;
    logic       BUSY;

    int n_checks = 0;
    int n_errors = 0;
    int fd_count = 0;
    int fd0;

    usonic_tx_scheduler #(
        .NUM_CH        (NUM_CH),
        .HALF_PERIOD   (HP),
        .BURST_PULSES  (BP),
        .LISTEN_CYCLES (LC)
    ) dut (
        .CLK_40      (CLK_40),
        .RST_N       (RST_N),
        .EN          (EN),
        .MODE_CONT   (MODE_CONT),
        .START       (START),
        .CH_MASK     (CH_MASK),
        .pulseOutput (pulseOutput),
        .CH_SEL      (CH_SEL),
        .TX_ACTIVE   (TX_ACTIVE),
        .LISTEN      (LISTEN),
        .FRAME_DONE  (FRAME_DONE),
        .BUSY        (BUSY)
    );

    always #5 CLK_40 = ~CLK_40;

    always @(posedge CLK_40) begin
        if (FRAME_DONE === 1'b1) fd_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK_40);
        @(negedge CLK_40);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_pulse(input int ch, input logic p);
        logic [7:0] v;
        v = '0;
        v[2*ch]   = p;
        v[2*ch+1] = ~p;
        return v;
    endfunction

    task automatic do_burst(input int ch, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            step();
            chk("burst_pulse", pulseOutput, exp_pulse(ch, (k % (2*HP)) < HP));
            chk("burst_tx", TX_ACTIVE, 1);
            chk("burst_sel", CH_SEL, ch);
        end
    endtask

    task automatic do_listen(input int ch, input int start_at);
        for (int k = 0; k < LC; k++) begin
            step();
            START = (k == start_at);
            chk("listen_flag", LISTEN, 1);
            chk("listen_pulse", pulseOutput, 0);
            chk("listen_tx", TX_ACTIVE, 0);
            chk("listen_done", FRAME_DONE, (k == LC - 1));
            chk("listen_sel", CH_SEL, ch);
        end
        START = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0; EN = 1'b0; MODE_CONT = 1'b0; START = 1'b0; CH_MASK = 4'b0000;
        repeat (3) @(negedge CLK_40);
        chk("rst_pulse", pulseOutput, 0);
        chk("rst_sel", CH_SEL, 0);
        chk("rst_tx", TX_ACTIVE, 0);
        chk("rst_listen", LISTEN, 0);
        chk("rst_fd", FRAME_DONE, 0);
        chk("rst_busy", BUSY, 0);
        RST_N = 1'b1;
        step();
        chk("post_rst_busy", BUSY, 0);

        // Single sweep over ch0 and ch2
        EN = 1'b1; CH_MASK = 4'b0101; START = 1'b1;
        fd0 = fd_count;
        step();
        START = 1'b0;
        chk("sel_busy", BUSY, 1);
        chk("sel_tx", TX_ACTIVE, 0);
        chk("sel_pulse", pulseOutput, 0);
        do_burst(0, BURST_LEN);
        do_listen(0, -1);
        step();
        chk("sel2_busy", BUSY, 1);
        chk("sel2_pulse", pulseOutput, 0);
        do_burst(2, BURST_LEN);
        do_listen(2, -1);
        step();
        chk("sweep_end_busy", BUSY, 0);
        step();
        chk("sweep_fd_count", fd_count - fd0, 2);

        // Continuous on ch3: SELECT + burst + listen back to back, then abort
        CH_MASK = 4'b1000; MODE_CONT = 1'b1;
        step();
        chk("cont_sel_busy", BUSY, 1);
        do_burst(3, BURST_LEN);
        do_listen(3, -1);
        step();
        chk("cont_sel2_busy", BUSY, 1);
        chk("cont_sel2_tx", TX_ACTIVE, 0);
        chk("cont_sel2_ch", CH_SEL, 3);
        do_burst(3, BURST_LEN);
        do_listen(3, -1);
        step();
        chk("cont_sel3_busy", BUSY, 1);
        do_burst(3, 10);
        EN = 1'b0;
        fd0 = fd_count;
        step();
        chk("abort_pulse", pulseOutput, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_tx", TX_ACTIVE, 0);
        chk("abort_listen", LISTEN, 0);
        repeat (30) step();
        chk("abort_stay_idle", BUSY, 0);
        chk("abort_no_fd", fd_count - fd0, 0);
        MODE_CONT = 1'b0;
        EN = 1'b1;
        step();
        chk("idle_no_start", BUSY, 0);

        // Mask edit mid-sweep must not change the current sweep
        CH_MASK = 4'b0011; START = 1'b1;
        step();
        START = 1'b0; CH_MASK = 4'b1100;
        chk("medit_sel_busy", BUSY, 1);
        do_burst(0, BURST_LEN);
        do_listen(0, -1);
        step();
        chk("medit_sel2_busy", BUSY, 1);
        do_burst(1, BURST_LEN);
        do_listen(1, -1);
        step();
        chk("medit_end_busy", BUSY, 0);
        step();
        chk("medit_stay_idle", BUSY, 0);

        // START with empty mask
        CH_MASK = 4'b0000; START = 1'b1;
        step();
        START = 1'b0;
        chk("zmask_busy", BUSY, 0);
        chk("zmask_pulse", pulseOutput, 0);
        step();
        chk("zmask_busy2", BUSY, 0);

        // START during LISTEN is dropped
        CH_MASK = 4'b0001; START = 1'b1;
        step();
        START = 1'b0;
        do_burst(0, BURST_LEN);
        do_listen(0, 5);
        step();
        chk("lstart_end_busy", BUSY, 0);
        repeat (3) step();
        chk("lstart_no_sweep", BUSY, 0);
        chk("lstart_no_tx", TX_ACTIVE, 0);

        // Asynchronous reset mid-burst on ch2
        CH_MASK = 4'b0100; START = 1'b1;
        step();
        START = 1'b0;
        do_burst(2, 5);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_pulse", pulseOutput, 0);
        chk("arst_sel", CH_SEL, 0);
        chk("arst_tx", TX_ACTIVE, 0);
        chk("arst_listen", LISTEN, 0);
        chk("arst_fd", FRAME_DONE, 0);
        chk("arst_busy", BUSY, 0);
        @(negedge CLK_40);
        RST_N = 1'b1;
        step();
        chk("arst_idle", BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usonic_tx_scheduler.md
USONIC_TX_SCHEDULER -- requirements
Module: usonic_tx_scheduler

Interface
REQ-001 Parameters SHALL be:
  - NUM_CH, default 4: number of transmitter channels.
  - HALF_PERIOD, default 512: clocks per half carrier period.
  - BURST_PULSES, default 32: carrier periods per burst.
  - LISTEN_CYCLES, default 560000: echo-listen clocks after each burst.
REQ-002 Ports SHALL be:
  - CLK_40  in  1  40 MHz clock; the only clock.
  - RST_N  in  1  asynchronous active-low reset.
  - EN  in  1  global enable.
  - MODE_CONT  in  1  1 = continuous sweeps, 0 = single sweep per START.
  - START  in  1  single-cycle sweep request.
  - CH_MASK  in  NUM_CH  channels included in a sweep.
  - pulseOutput  out  2*NUM_CH  differential pair per channel, {n,p} at bits [2c+1:2c].
  - CH_SEL  out  clog2(NUM_CH)  channel currently bursting or listening.
  - TX_ACTIVE  out  1  high during BURST.
  - LISTEN  out  1  high during LISTEN.
  - FRAME_DONE  out  1  one-cycle pulse at the end of each channel's listen window.
  - BUSY  out  1  high whenever state != IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, SELECT, BURST and LISTEN, with every output registered.
REQ-004 IDLE -> SELECT SHALL occur when EN=1, the sampled mask is nonzero, and either MODE_CONT=1 or START=1.
REQ-005 CH_MASK SHALL be latched into a sweep mask on the IDLE -> SELECT transition; later changes to CH_MASK SHALL take effect only at the next sweep start.
REQ-006 SELECT SHALL last exactly 1 cycle and pick the lowest pending channel of the sweep mask, set CH_SEL, clear that channel's pending bit, then go to BURST.
REQ-007 BURST SHALL last exactly 2*HALF_PERIOD*BURST_PULSES cycles.
  - p bit of the selected pair: high for HALF_PERIOD cycles, then low for HALF_PERIOD, starting high on the first BURST cycle.
  - n bit SHALL be ~p.
REQ-008 Non-selected pairs, and all pairs outside BURST, SHALL drive {0,0} (transducer de-energised).
REQ-009 LISTEN SHALL last exactly LISTEN_CYCLES cycles, and FRAME_DONE SHALL pulse on its last cycle.
REQ-010 On LISTEN exit:
  - pending bits remain -> SELECT;
  - none remain and MODE_CONT=1 and EN=1 -> reload the sweep mask from CH_MASK and go to SELECT (or IDLE if CH_MASK=0);
  - otherwise -> IDLE.
REQ-011 START outside IDLE SHALL be ignored and not queued.
REQ-012 EN=0 in any state SHALL force IDLE on the next edge and clear pending bits; pulseOutput goes to all-zero on that same edge, with no partial-period completion.
REQ-013 A zero CH_MASK at START SHALL leave the block in IDLE with no outputs asserted.
REQ-014 The half-period, pulse and listen counters SHALL be sized to their parameters and reset to 0 on every state entry; none SHALL wrap inside a state.
REQ-015 Continuous mode SHALL sweep channels in ascending index order, with no idle cycles between LISTEN and SELECT.

Reset
REQ-016 While RST_N=0 the block SHALL force:
  - state = IDLE;
  - all counters and pending bits = 0;
  - pulseOutput = 0, CH_SEL = 0, TX_ACTIVE = LISTEN = FRAME_DONE = BUSY = 0.
REQ-017 After RST_N deasserts, the block SHALL first act on the first rising CLK_40 edge that sees RST_N=1.

Structure
REQ-018 The state enum and parameter defaults SHALL live in the shared package usonic_pkg.
REQ-019 The carrier half-period/pulse counting SHALL be one sub-module, usonic_carrier_gen (inputs: run; outputs: carrier, burst_last), instantiated once.

Verification
All scenarios use HALF_PERIOD=4, BURST_PULSES=3, LISTEN_CYCLES=20, NUM_CH=4.
REQ-020 Single sweep: CH_MASK=4'b0101, MODE_CONT=0, START pulse ->
  - ch0 burst of 24 cycles with p pattern 11110000 repeated 3 times;
  - 20 LISTEN cycles, then FRAME_DONE;
  - ch2 burst and listen, then FRAME_DONE;
  - BUSY falls; exactly 2 FRAME_DONE pulses.
REQ-021 Continuous: MODE_CONT=1, CH_MASK=4'b1000 -> ch3 bursts repeat with period 1+24+20=45 cycles, CH_SEL=3 throughout.
REQ-022 Abort: EN deasserted on the 10th BURST cycle -> next edge gives pulseOutput=0, state IDLE, no FRAME_DONE.
REQ-023 Mask edits: CH_MASK changed 4'b0011 -> 4'b1100 mid-sweep -> current sweep still serves ch0 and ch1 only.
REQ-024 Edge cases:
  - START with CH_MASK=0 -> BUSY stays 0;
  - START during LISTEN -> no extra sweep;
  - RST_N asserted mid-BURST -> all outputs 0 immediately, asynchronously.
